// File: rtl/riscv_ex_wb_buffer.sv
// EX-to-WB in-order result queue with DIFT tag pass-through
// and a combinational youngest-match forwarding lookup.
module riscv_ex_wb_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 1,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [ADDR_WIDTH-1:0]        in_waddr_i,
  input  logic [DATA_WIDTH-1:0]        in_wdata_i,
  input  logic [TAG_WIDTH-1:0]         in_wdata_tag_i,
  input  logic                         in_we_tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [ADDR_WIDTH-1:0]        out_waddr_o,
  output logic [DATA_WIDTH-1:0]        out_wdata_o,
  output logic [TAG_WIDTH-1:0]         out_wdata_tag_o,
  output logic                         out_we_tag_o,
  input  logic [ADDR_WIDTH-1:0]        fwd_raddr_i,
  output logic                         fwd_hit_o,
  output logic [DATA_WIDTH-1:0]        fwd_wdata_o,
  output logic [TAG_WIDTH-1:0]         fwd_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = CNT_W + 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] waddr_q [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_q [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q   [DEPTH];
  logic                  wetag_q [DEPTH];

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  assign in_ready_o  = (count_q < CNT_FULL);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  assign out_waddr_o     = waddr_q[rptr_q];
  assign out_wdata_o     = wdata_q[rptr_q];
  assign out_wdata_tag_o = tag_q[rptr_q];
  assign out_we_tag_o    = wetag_q[rptr_q];
  assign count_o         = count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
      rptr_d  = wptr_q;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
        tag_q[i]   <= '0;
        wetag_q[i] <= 1'b0;
      end
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      if (push && !flush_i) begin
        waddr_q[wptr_q] <= in_waddr_i;
        wdata_q[wptr_q] <= in_wdata_i;
        tag_q[wptr_q]   <= in_wdata_tag_i;
        wetag_q[wptr_q] <= in_we_tag_i;
      end
    end
  end

  // Age 0 is the head; the occupied entry with the largest age wins.
  logic [AGE_W-1:0] slot;
  logic [AGE_W-1:0] rp;
  logic [AGE_W-1:0] age;
  logic [AGE_W-1:0] best_age;

  always_comb begin
    fwd_hit_o   = 1'b0;
    fwd_wdata_o = '0;
    fwd_tag_o   = '0;
    best_age    = '0;
    slot        = '0;
    age         = '0;
    rp          = AGE_W'(rptr_q);
    for (int s = 0; s < DEPTH; s++) begin
      slot = AGE_W'(s);
      age  = (slot >= rp) ? (slot - rp)
                          : (slot + AGE_W'(DEPTH) - rp);
      if ((fwd_raddr_i != '0) &&
          (age < AGE_W'(count_q)) &&
          (waddr_q[s] == fwd_raddr_i) &&
          (!fwd_hit_o || (age > best_age))) begin
        fwd_hit_o   = 1'b1;
        best_age    = age;
        fwd_wdata_o = wdata_q[s];
        fwd_tag_o   = tag_q[s];
      end
    end
  end

endmodule

// File: tb/tb_riscv_ex_wb_buffer.sv
// Directed bench: DEPTH=2 instance for ordering, forwarding, flush
// and reset; DEPTH=3 instance for back-to-back streaming wrap.
module tb_riscv_ex_wb_buffer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic        a_flush, a_ivalid, a_iready, a_iwetag, a_itag;
  logic [4:0]  a_iwaddr, a_owaddr, a_fraddr;
  logic [31:0] a_iwdata, a_owdata, a_fdata;
  logic        a_ovalid, a_oready, a_otag, a_owetag, a_fhit, a_ftag;
  logic [1:0]  a_count;

  logic        b_flush, b_ivalid, b_iready, b_iwetag, b_itag;
  logic [4:0]  b_iwaddr, b_owaddr, b_fraddr;
  logic [31:0] b_iwdata, b_owdata, b_fdata;
  logic        b_ovalid, b_oready, b_otag, b_owetag, b_fhit, b_ftag;
  logic [1:0]  b_count;

  riscv_ex_wb_buffer #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
    .in_valid_i(a_ivalid), .in_ready_o(a_iready),
    .in_waddr_i(a_iwaddr), .in_wdata_i(a_iwdata),
    .in_wdata_tag_i(a_itag), .in_we_tag_i(a_iwetag),
    .out_valid_o(a_ovalid), .out_ready_i(a_oready),
    .out_waddr_o(a_owaddr), .out_wdata_o(a_owdata),
    .out_wdata_tag_o(a_otag), .out_we_tag_o(a_owetag),
    .fwd_raddr_i(a_fraddr), .fwd_hit_o(a_fhit),
    .fwd_wdata_o(a_fdata), .fwd_tag_o(a_ftag),
    .count_o(a_count)
  );

  riscv_ex_wb_buffer #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
    .in_valid_i(b_ivalid), .in_ready_o(b_iready),
    .in_waddr_i(b_iwaddr), .in_wdata_i(b_iwdata),
    .in_wdata_tag_i(b_itag), .in_we_tag_i(b_iwetag),
    .out_valid_o(b_ovalid), .out_ready_i(b_oready),
    .out_waddr_o(b_owaddr), .out_wdata_o(b_owdata),
    .out_wdata_tag_o(b_otag), .out_we_tag_o(b_owetag),
    .fwd_raddr_i(b_fraddr), .fwd_hit_o(b_fhit),
    .fwd_wdata_o(b_fdata), .fwd_tag_o(b_ftag),
    .count_o(b_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [4:0] wa,
                        input logic [31:0] wd,
                        input logic tg);
    a_ivalid = 1'b1;
    a_iwaddr = wa;
    a_iwdata = wd;
    a_itag   = tg;
    a_iwetag = tg;
  endtask

  initial begin
    rst_n    = 1'b0;
    a_flush  = 0; a_ivalid = 0; a_iwaddr = 0; a_iwdata = 0;
    a_itag   = 0; a_iwetag = 0; a_oready = 0; a_fraddr = 0;
    b_flush  = 0; b_ivalid = 0; b_iwaddr = 0; b_iwdata = 0;
    b_itag   = 0; b_iwetag = 0; b_oready = 0; b_fraddr = 0;

    tick();
    tick();
    a_fraddr = 5'd5;
    #1;
    chk("rst_ready", a_iready, 1);
    chk("rst_valid", a_ovalid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_fhit", a_fhit, 0);
    chk("rst_fdata", a_fdata, 0);
    chk("rst_b_count", b_count, 0);
    rst_n = 1'b1;

    a_push(5'd5, 32'hDEAD_BEEF, 1'b1);
    tick();
    chk("p1_count", a_count, 1);
    chk("p1_valid", a_ovalid, 1);
    chk("p1_waddr", a_owaddr, 5);
    chk("p1_wdata", a_owdata, 32'hDEAD_BEEF);
    chk("p1_tag", a_otag, 1);
    a_push(5'd6, 32'h1234, 1'b0);
    tick();
    chk("full_count", a_count, 2);
    chk("full_ready", a_iready, 0);
    a_push(5'd8, 32'h8888, 1'b0);
    tick();
    chk("stall_count", a_count, 2);
    chk("stall_head", a_owaddr, 5);
    a_oready = 1'b1;
    tick();
    chk("pop1_count", a_count, 1);
    chk("pop1_waddr", a_owaddr, 6);
    chk("pop1_wdata", a_owdata, 32'h1234);
    chk("pop1_tag", a_otag, 0);
    chk("pop1_ready", a_iready, 1);
    tick();
    chk("pop2_count", a_count, 1);
    chk("pop2_waddr", a_owaddr, 8);
    chk("pop2_wdata", a_owdata, 32'h8888);
    a_ivalid = 1'b0;
    tick();
    chk("drain_count", a_count, 0);
    chk("drain_valid", a_ovalid, 0);

    a_oready = 1'b0;
    a_push(5'd7, 32'h11, 1'b0);
    tick();
    a_push(5'd7, 32'h22, 1'b1);
    tick();
    a_ivalid = 1'b0;
    a_fraddr = 5'd7;
    #1;
    chk("fwd_count", a_count, 2);
    chk("fwd_hit", a_fhit, 1);
    chk("fwd_data", a_fdata, 32'h22);
    chk("fwd_tag", a_ftag, 1);
    a_oready = 1'b1;
    a_fraddr = 5'd6;
    #1;
    chk("fwd_miss_hit", a_fhit, 0);
    chk("fwd_miss_data", a_fdata, 0);
    tick();
    a_oready = 1'b0;
    a_push(5'd0, 32'h55, 1'b1);
    tick();
    a_ivalid = 1'b0;
    a_fraddr = 5'd0;
    #1;
    chk("x0_count", a_count, 2);
    chk("x0_fhit", a_fhit, 0);
    chk("x0_fdata", a_fdata, 0);
    a_fraddr = 5'd7;
    #1;
    chk("fwd_after_pop", a_fdata, 32'h22);

    a_flush = 1'b1;
    a_push(5'd9, 32'h99, 1'b1);
    tick();
    a_flush  = 1'b0;
    a_ivalid = 1'b0;
    a_fraddr = 5'd9;
    #1;
    chk("fl_count", a_count, 0);
    chk("fl_valid", a_ovalid, 0);
    chk("fl_ready", a_iready, 1);
    chk("fl_hit9", a_fhit, 0);
    a_fraddr = 5'd7;
    #1;
    chk("fl_hit7", a_fhit, 0);

    a_push(5'd1, 32'hA1, 1'b0);
    tick();
    a_push(5'd2, 32'hA2, 1'b1);
    tick();
    chk("pre_rst_count", a_count, 2);
    rst_n    = 1'b0;
    a_flush  = 1'b1;
    a_push(5'd4, 32'hA4, 1'b1);
    tick();
    a_fraddr = 5'd1;
    #1;
    chk("mrst_count", a_count, 0);
    chk("mrst_valid", a_ovalid, 0);
    chk("mrst_ready", a_iready, 1);
    chk("mrst_waddr", a_owaddr, 0);
    chk("mrst_wdata", a_owdata, 0);
    chk("mrst_fhit", a_fhit, 0);
    rst_n   = 1'b1;
    a_flush = 1'b0;
    a_push(5'd3, 32'hC3, 1'b1);
    tick();
    a_ivalid = 1'b0;
    chk("post_valid", a_ovalid, 1);
    chk("post_waddr", a_owaddr, 3);
    chk("post_wdata", a_owdata, 32'hC3);
    chk("post_wetag", a_owetag, 1);

    b_oready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_ivalid = 1'b1;
      b_iwaddr = 5'(i + 1);
      b_iwdata = 32'h100 + 32'(i);
      tick();
      chk("st_count", b_count, 1);
      chk("st_waddr", b_owaddr, 64'(i + 1));
      chk("st_wdata", b_owdata, 64'h100 + 64'(i));
    end
    b_ivalid = 1'b0;
    tick();
    chk("st_drain", b_count, 0);
    chk("st_valid", b_ovalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/riscv_ex_wb_buffer.md
Name: riscv_ex_wb_buffer

Overview:
Parametrised EX-to-WB result buffer that replaces the single-entry EX/WB register with a DEPTH-entry in-order queue. It carries the write-back address, the data, and the DIFT tag bits. It decouples ex_valid from wb_ready through a valid/ready handshake on both sides. A combinational forwarding lookup lets the ID stage read the youngest pending result for a given register.

Parameters:
DATA_WIDTH, 32, width of write-back data
TAG_WIDTH, 1, width of DIFT data tag (0 not allowed; tie off when unused)
ADDR_WIDTH, 5, register-file address width
DEPTH, 2, number of entries (>=1, any integer)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
flush_i  in  1  discard all entries (exception/branch kill)
in_valid_i  in  1  EX result valid
in_ready_o  out  1  buffer can accept
in_waddr_i  in  ADDR_WIDTH  destination register
in_wdata_i  in  DATA_WIDTH  result data
in_wdata_tag_i  in  TAG_WIDTH  result data tag
in_we_tag_i  in  1  tag write enable for this result
out_valid_o  out  1  head entry valid to WB
out_ready_i  in  1  WB accepts head
out_waddr_o  out  ADDR_WIDTH  head register
out_wdata_o  out  DATA_WIDTH  head data
out_wdata_tag_o  out  TAG_WIDTH  head data tag
out_we_tag_o  out  1  head tag write enable
fwd_raddr_i  in  ADDR_WIDTH  forwarding lookup address
fwd_hit_o  out  1  lookup matched a pending entry
fwd_wdata_o  out  DATA_WIDTH  matched data
fwd_tag_o  out  TAG_WIDTH  matched tag
count_o  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n low at clk edge): count, read/write pointers and all storage = 0. Outputs then read: in_ready_o=1, out_valid_o=0, out_* data=0, fwd_hit_o=0, fwd_* =0, count_o=0. Reset overrides flush and all handshakes. Reset mid-stream drops every entry.
- Push: occurs when in_valid_i & in_ready_o. Entry written at the write pointer; pointer advances modulo DEPTH (wraps DEPTH-1 -> 0, including non-power-of-2 DEPTH).
- Pop: occurs when out_valid_o & out_ready_i. Read pointer advances modulo DEPTH.
- in_ready_o = (count < DEPTH). It does not depend on out_ready_i, so there is no combinational ready path. When full, a same-cycle pop does not enable a push.
- out_valid_o = (count != 0). The out_* fields are driven combinationally from the head entry.
- Latency: a push at edge N is visible on out_* after edge N (one cycle). There is no same-cycle bypass from in_* to out_*.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Empty: out_valid_o=0. out_* hold the stale head storage content; WB must ignore them.
- Full: in_ready_o=0. Any in_valid_i is held by the producer; no data is lost.
- flush_i: synchronous. On the next edge, count=0 and read pointer = write pointer. A push and/or pop in the flush cycle is discarded; flush wins. Storage contents are not cleared.
- Entries with waddr 0 are queued and drained normally; WB discards them.
- Forwarding (combinational):
  - fwd_hit_o=1 iff fwd_raddr_i != 0 and at least one occupied entry has waddr == fwd_raddr_i.
  - fwd_wdata_o/fwd_tag_o come from the youngest matching entry, i.e. the one closest to the write pointer.
  - On a miss, fwd_wdata_o=0 and fwd_tag_o=0.
  - The lookup covers stored entries only, not the in_* port in the same cycle.
  - An entry being popped in the current cycle still participates.
- Tag fields are pass-through. The buffer does not apply any tag propagation policy.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> in_ready_o=1, out_valid_o=0, count_o=0, fwd_hit_o=0 for any fwd_raddr_i.
- DEPTH=2, out_ready_i=0, push (x5, 0xDEAD_BEEF, tag 1), then (x6, 0x1234, tag 0) -> count_o=2, in_ready_o=0. A third in_valid_i is stalled. Release out_ready_i -> outputs x5 then x6 in order, one per cycle.
- Forwarding: queue holds x7=0x11 (older) and x7=0x22 (younger) with tags 0/1; fwd_raddr_i=7 -> hit=1, data=0x22, tag=1. fwd_raddr_i=0 with an x0 entry queued -> hit=0.
- Streaming at DEPTH=3, out_ready_i=1: 10 back-to-back pushes -> each appears one cycle later, count_o stays 1, pointers wrap cleanly past index 2.
- Flush with count=2 while pushing x9 in the same cycle -> next cycle count_o=0, out_valid_o=0, fwd_hit_o=0 for x9 and for prior entries.
- Reset mid-operation: count=2, assert rst_n=0 together with in_valid_i=1 and flush_i=1 -> next cycle all outputs at reset values. The first push after reset appears on out_* one cycle later.
